stream_fifo_src: RTL
====================

Name: stream_fifo_src

Overview:
- Elastic buffer stage directly upstream of the streaming sum accumulator.
- Accepts signed WIDTH-bit stream elements from a producer via valid/ready and stores them in a DEPTH-entry circular buffer.
- Presents them in order, one per cycle, as the accumulator's sIn stream.
- Tags the final element of each stream (last) and counts completed streams so the consumer knows when a sum is final.

Parameters:
- WIDTH, 8, element width in bits; matches the codebase `intN.
- DEPTH, 4, buffer entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of buffer contents and counters
- in_valid  input  1  producer has an element
- in_ready  output  1  buffer can accept; equals !full
- in_data  input  WIDTH  element, two's complement
- in_last  input  1  element is the last of its stream
- out_valid  output  1  out_data/out_last hold the head element
- out_ready  input  1  consumer takes the head this cycle
- out_data  output  WIDTH  head element
- out_last  output  1  head element's last tag
- count  output  AW+1  occupancy, 0..DEPTH
- streams  output  8  number of last-tagged elements delivered; saturates at 255

Behaviour:
- Reset (nrst low, asynchronous):
  - rd_ptr, wr_ptr and count are 0.
  - out_valid is 0; out_data and out_last are 0.
  - streams is 0; in_ready is 1.
  - Memory contents are don't-care.
- Write handshake: an element is accepted when in_valid and in_ready are both high at a rising edge. It is stored at wr_ptr, then wr_ptr increments modulo DEPTH.
- Read handshake: the head is consumed when out_valid and out_ready are both high. rd_ptr then increments modulo DEPTH.
- Output timing: out_valid is high exactly when count is nonzero. out_data and out_last are driven from the memory at rd_ptr, so the head is valid with no extra register stage.
- Latency: an element written at edge N is visible at the output after edge N, so in cycle N+1. There is no combinational bypass from in_data to out_data.
- Full (count == DEPTH):
  - in_ready is 0; in_valid is ignored and in_data is not stored.
  - A simultaneous read frees a slot, but in_ready stays low that cycle (in_ready has no dependency on out_ready). The write is accepted on the following cycle.
- Empty (count == 0):
  - out_valid is 0 and out_ready is ignored; pointers do not move.
  - A write in this cycle yields out_valid = 1 in the next cycle.
- Simultaneous accept and consume (not full, not empty): both pointers advance and count is unchanged.
- Otherwise count increments on an accept and decrements on a consume.
- Wrap-around: pointers roll from DEPTH-1 to 0. Order is preserved across the wrap.
- streams: increments by 1 on each consume whose out_last is 1. Holds at 255 once reached.
- flush (synchronous):
  - Sets rd_ptr, wr_ptr, count and streams to 0 at the next edge.
  - Takes precedence over any accept or consume in the same cycle; a concurrent in_valid element is discarded.
  - in_ready is unaffected during the flush cycle (it is still !full).
- Reset mid-operation: all state clears immediately on nrst falling, regardless of clk. Handshakes resume on the first rising edge after nrst rises.
- Data is carried bit-exact; there is no sign handling beyond storage. Values such as 8'hff pass through unchanged.
- in_data and in_last are sampled only on accepted cycles.

Test Plan:
1. Reset then stream: nrst low 2 cycles, then write 1, 2, 3, 8'hff (last on 8'hff) with out_ready high. Required: out_data shows 1, 2, 3, 8'hff, one per cycle, each one cycle after its write. out_last is 1 only with 8'hff. streams = 1 afterwards. The downstream sum is 5 (8'h05).
2. Fill to full: out_ready low, offer 5 elements 10..14. Required: 10..13 accepted, in_ready = 0 after the 4th accept, count = 4, and 14 is held by the producer. Then raise out_ready for 1 cycle: 10 is consumed, and 14 is accepted the following cycle.
3. Wrap-around order: 12 writes and 12 reads interleaved with random out_ready gaps. Required: the output sequence equals the input sequence exactly, and count never exceeds 4 nor underflows.
4. Simultaneous read/write at count = 2: count stays 2, and the head advances to the next stored element.
5. Flush and async reset: with count = 3 and streams = 1, assert flush while in_valid is high with 7. Required: the next cycle has count = 0, out_valid = 0, streams = 0, and 7 is not stored. Separately, pull nrst low mid-clock-period with count = 2. Required: out_valid drops to 0 before the next edge.
6. streams saturation: deliver 260 single-element last-tagged streams. Required: streams reads 255 and holds.

Source files
------------

// File: rtl/stream_fifo_src.sv
// Elastic circular buffer feeding the streaming sum accumulator: valid/ready in,
// head presented straight from memory, last-tag tracking and a saturating stream count.
module stream_fifo_src #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [AW:0]      count,
  output logic [7:0]       streams
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [7:0]                streams_q, streams_d;
  logic [DEPTH-1:0][WIDTH:0] mem_q, mem_d;
  logic                      wr_en, rd_en;

  // in_ready looks only at occupancy, never at out_ready, so a full buffer
  // being drained still refuses the write until the following cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
  assign out_last  = out_valid & mem_q[rd_ptr_q][WIDTH];
  assign count     = count_q;
  assign streams   = streams_q;

  assign wr_en = in_valid & in_ready;
  assign rd_en = out_valid & out_ready;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    streams_d = streams_q;
    mem_d     = mem_q;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      streams_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = {in_last, in_data};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (out_last && streams_q != 8'hff) streams_d = streams_q + 8'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      streams_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      streams_q <= streams_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
